// File: rtl/xpb_pkg.sv
// rtl/xpb_pkg.sv - shared types and defaults for the xpb lookup table (XPB_LUT_OUT_PIPE_EN)
package xpb_pkg;

    localparam int XPB_WORD_W = 1024;
    localparam int XPB_IDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } xpb_state_e;

    function automatic int lookup_latency();
`ifdef XPB_LUT_OUT_PIPE_EN
        return 2;
`else
        return 1;
`endif
    endfunction

endpackage

// File: rtl/xpb_modadd.sv
// rtl/xpb_modadd.sv - combinational modular add, y = (a + b) mod n for a, b < n
module xpb_modadd #(
    parameter int W = 1024
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] y
);

    logic [W:0]   s;
    logic [W-1:0] t;

    // The carry bit of s decides the compare; only the low bits of s - n are ever kept.
    assign s = {1'b0, a} + {1'b0, b};
    assign t = s[W-1:0] - n;
    assign y = (s >= {1'b0, n}) ? t : s[W-1:0];

endmodule

// File: rtl/xpb_lut_gen.sv
// rtl/xpb_lut_gen.sv - runtime-generated k*B mod N table with NUM_CH registered lookups (XPB_LUT_OUT_PIPE_EN)
module xpb_lut_gen
    import xpb_pkg::*;
#(
    parameter int WORD_W = XPB_WORD_W,
    parameter int IDX_W  = XPB_IDX_W,
    parameter int NUM_CH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_start,
    input  logic [WORD_W-1:0]        base_in,
    input  logic [WORD_W-1:0]        mod_in,
    output logic                     init_busy,
    output logic                     init_done,
    output logic                     table_valid,
    input  logic                     lk_valid,
    input  logic [NUM_CH*IDX_W-1:0]  lk_idx,
    output logic                     out_valid,
    output logic [NUM_CH*WORD_W-1:0] out_data,
    output logic                     lk_err
);

    localparam int DEPTH = 1 << IDX_W;

    xpb_state_e          state, state_nxt;
    logic                start_acc;
    logic [WORD_W-1:0]   b_reg, n_reg, acc, acc_nxt;
    logic [IDX_W-1:0]    k;
    logic [WORD_W-1:0]   tbl [DEPTH];
    logic [NUM_CH*WORD_W-1:0] rd_data;
    logic                lk_hit, lk_miss;
    logic                s1_valid, s1_err;
    logic [NUM_CH*WORD_W-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (init_start) state_nxt = GEN;
            GEN:     if (&k)         state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        init_busy = (state == GEN);
        init_done = (state == DONE);
        start_acc = (state == IDLE) && init_start;
    end

    xpb_modadd #(.W(WORD_W)) u_modadd (
        .a (acc),
        .b (b_reg),
        .n (n_reg),
        .y (acc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_reg       <= '0;
            n_reg       <= '0;
            acc         <= '0;
            k           <= '0;
            table_valid <= 1'b0;
        end else begin
            if (start_acc) begin
                b_reg       <= base_in;
                n_reg       <= mod_in;
                acc         <= '0;
                k           <= '0;
                table_valid <= 1'b0;
            end else if (init_busy) begin
                acc <= acc_nxt;
                k   <= k + 1'b1;
            end
            if (init_done) table_valid <= 1'b1;
        end
    end

    // Storage is deliberately unreset; table_valid gates every use of it.
    always_ff @(posedge clk) begin
        if (init_busy) tbl[k] <= acc;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_rd
        assign rd_data[c*WORD_W +: WORD_W] = tbl[lk_idx[c*IDX_W +: IDX_W]];
    end

    // table_valid is still high in the IDLE cycle that accepts init_start, so that lookup hits the old table.
    assign lk_hit  = lk_valid &  table_valid;
    assign lk_miss = lk_valid & ~table_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= lk_hit;
            s1_err   <= lk_miss;
            if (lk_hit) s1_data <= rd_data;
        end
    end

`ifdef XPB_LUT_OUT_PIPE_EN
    logic                     s2_valid, s2_err;
    logic [NUM_CH*WORD_W-1:0] s2_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_err   <= s1_err;
            if (s1_valid) s2_data <= s1_data;
        end
    end

    assign out_valid = s2_valid;
    assign lk_err    = s2_err;
    assign out_data  = s2_data;
`else
    assign out_valid = s1_valid;
    assign lk_err    = s1_err;
    assign out_data  = s1_data;
`endif

endmodule
